// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: operand geometry and the skew feeder state encoding.
package sa_pkg;

  localparam int SA_WIDTH = 8;
  localparam int SA_LANES = 4;
  localparam int SA_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2,
    ST_STREAM  = 2'd3
  } state_e;

endpackage

// File: rtl/tile_buf.sv
// Tile storage: DEPTH row vectors, one write port, LANES independent lane read ports.
module tile_buf #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [LANES*WIDTH-1:0] wdata,
  input  logic [LANES*AW-1:0]    raddr,
  output logic [LANES*WIDTH-1:0] rdata
);

  // No reset: rows are only read after they have been rewritten.
  logic [LANES*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Each lane reads its own lane slice from its own row address.
  for (genvar i = 0; i < LANES; i++) begin : g_lane_rd
    assign rdata[i*WIDTH +: WIDTH] = mem[raddr[i*AW +: AW]][i*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/pe_skew_feeder.sv
// Loads a DEPTH-row tile, then streams it diagonally skewed (lane i delayed by i steps) to a PE array edge.
module pe_skew_feeder
  import sa_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int LANES = SA_LANES,
  parameter int DEPTH = SA_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [LANES*WIDTH-1:0] wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   pe_enable,
  output logic [LANES*WIDTH-1:0] a_out,
  output logic                   done,
  output state_e                 dbg_state
);

  localparam int STEPS = DEPTH + LANES - 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(STEPS + 1);

  state_e                 state_q;
  logic [CW-1:0]          count;
  logic [SW-1:0]          step;
  logic [SW-1:0]          next_step;
  logic                   wr_fire;
  logic [LANES*AW-1:0]    rd_addr;
  logic [LANES-1:0]       lane_hit;
  logic [LANES*WIDTH-1:0] rd_data;
  logic [LANES*WIDTH-1:0] skew_word;

  // Handshake: a row is taken on a rising edge where wr_valid and wr_ready are both high;
  // wr_ready is a registered function of state only, so it never depends on wr_valid.
  assign wr_fire   = wr_valid & wr_ready;
  assign dbg_state = state_q;

  tile_buf #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (count[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Address the step about to be registered: step 0 from FULL, otherwise the following step.
  always_comb begin
    next_step = (state_q == ST_FULL) ? '0 : step + SW'(1);
    rd_addr   = '0;
    lane_hit  = '0;
    skew_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((int'(next_step) >= i) && (int'(next_step) - i < DEPTH)) begin
        lane_hit[i]              = 1'b1;
        rd_addr[i*AW +: AW]      = AW'(int'(next_step) - i);
        skew_word[i*WIDTH +: WIDTH] = rd_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      count     <= '0;
      step      <= '0;
      wr_ready  <= 1'b1;
      busy      <= 1'b0;
      pe_enable <= 1'b0;
      done      <= 1'b0;
      a_out     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_EMPTY, ST_LOADING: begin
          if (wr_fire) begin
            count <= count + CW'(1);
            if (count == CW'(DEPTH - 1)) begin
              state_q  <= ST_FULL;
              wr_ready <= 1'b0;
            end else begin
              state_q <= ST_LOADING;
            end
          end
        end
        ST_FULL: begin
          if (start) begin
            state_q   <= ST_STREAM;
            step      <= '0;
            busy      <= 1'b1;
            pe_enable <= 1'b1;
            a_out     <= skew_word;
          end
        end
        ST_STREAM: begin
          if (step == SW'(STEPS - 1)) begin
            // Tile finished: buffer keeps its rows, next tile overwrites them from row 0.
            state_q   <= ST_EMPTY;
            count     <= '0;
            step      <= '0;
            wr_ready  <= 1'b1;
            busy      <= 1'b0;
            pe_enable <= 1'b0;
            done      <= 1'b1;
            a_out     <= '0;
          end else begin
            step  <= next_step;
            a_out <= skew_word;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Randomized self-checking bench for pe_skew_feeder against a tile-level skew model.
module tb_pe_skew_feeder;
  import sa_pkg::*;

  localparam int W     = 8;
  localparam int L     = 4;
  localparam int D     = 4;
  localparam int DW    = L * W;
  localparam int STEPS = D + L - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          pe_enable;
  logic [DW-1:0] a_out;
  logic          done;
  state_e        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] tile_m [D];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] spec_seq [STEPS] = '{32'h00000001, 32'h00000205, 32'h00030609, 32'h04070A0D,
                                      32'h080B0E00, 32'h0C0F0000, 32'h10000000};
  logic [DW-1:0] spec_rows [D] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

  pe_skew_feeder #(.WIDTH(W), .LANES(L), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .pe_enable (pe_enable),
    .a_out     (a_out),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: step t, lane i carries lane i of row t-i when that row exists.
  function automatic logic [DW-1:0] model_word(input int t);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < L; i++) begin
      int r;
      r = t - i;
      if (r >= 0 && r < D) w[i*W +: W] = (tile_m[r] >> (i * W)) & ((1 << W) - 1);
    end
    return w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int idx, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
    tile_m[idx] = d;
  endtask

  task automatic load_tile(input bit use_spec);
    for (int r = 0; r < D; r++) write_row(r, use_spec ? spec_rows[r] : DW'($urandom));
  endtask

  task automatic run_stream(input bit use_spec, input bit disturb, input bit wr_in_done);
    logic [DW-1:0] d0;
    exp_q.delete();
    for (int t = 0; t < STEPS; t++) exp_q.push_back(use_spec ? spec_seq[t] : model_word(t));
    check_eq("full_state", 64'(dbg_state), 64'(ST_FULL));
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < STEPS; t++) begin
      check_eq($sformatf("pe_en_t%0d", t), 64'(pe_enable), 64'd1);
      check_eq($sformatf("busy_t%0d", t), 64'(busy), 64'd1);
      check_eq($sformatf("a_out_t%0d", t), 64'(a_out), 64'(exp_q.pop_front()));
      check_eq("no_ready_stream", 64'(wr_ready), 64'd0);
      if (disturb && t == 2) begin
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = DW'($urandom);
      end
      cyc();
      start    = 1'b0;
      wr_valid = 1'b0;
    end
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("done_pe_en", 64'(pe_enable), 64'd0);
    check_eq("done_busy", 64'(busy), 64'd0);
    check_eq("done_a_out", 64'(a_out), 64'd0);
    check_eq("done_ready", 64'(wr_ready), 64'd1);
    check_eq("done_state", 64'(dbg_state), 64'(ST_EMPTY));
    if (wr_in_done) begin
      d0 = DW'($urandom);
      write_row(0, d0);
      check_eq("done_wr_state", 64'(dbg_state), 64'(ST_LOADING));
      check_eq("done_wr_clear", 64'(done), 64'd0);
    end else begin
      cyc();
      check_eq("done_clear", 64'(done), 64'd0);
      check_eq("idle_pe_en", 64'(pe_enable), 64'd0);
      check_eq("idle_state", 64'(dbg_state), 64'(ST_EMPTY));
    end
  endtask

  initial begin
    int acc;
    logic [DW-1:0] d;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(wr_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_pe_en", 64'(pe_enable), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_a_out", 64'(a_out), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_EMPTY));
    reset = 1'b1;

    // Known tile against the published sequence.
    load_tile(1'b1);
    run_stream(1'b1, 1'b0, 1'b0);

    // Start while only partially loaded is ignored.
    write_row(0, DW'($urandom));
    write_row(1, DW'($urandom));
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("part_pe_en", 64'(pe_enable), 64'd0);
      check_eq("part_busy", 64'(busy), 64'd0);
      check_eq("part_state", 64'(dbg_state), 64'(ST_LOADING));
      check_eq("part_ready", 64'(wr_ready), 64'd1);
      cyc();
    end
    write_row(2, DW'($urandom));
    write_row(3, DW'($urandom));
    run_stream(1'b0, 1'b0, 1'b0);

    // Continuous wr_valid: only DEPTH rows are taken.
    acc = 0;
    wr_valid = 1'b1;
    for (int k = 0; k < D + 3; k++) begin
      d = DW'($urandom);
      wr_data = d;
      if (wr_ready) begin
        tile_m[acc] = d;
        acc++;
      end
      cyc();
    end
    wr_valid = 1'b0;
    check_eq("hold_accepted", 64'(acc), 64'(D));
    check_eq("hold_ready", 64'(wr_ready), 64'd0);
    run_stream(1'b0, 1'b0, 1'b0);

    // Start and write during streaming have no effect.
    load_tile(1'b0);
    run_stream(1'b0, 1'b1, 1'b0);

    // Reset mid-stream at step 3.
    load_tile(1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_a_out", 64'(a_out), 64'd0);
    check_eq("mid_rst_pe_en", 64'(pe_enable), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_ready", 64'(wr_ready), 64'd1);
    check_eq("mid_rst_state", 64'(dbg_state), 64'(ST_EMPTY));
    #2;
    reset = 1'b1;
    load_tile(1'b1);
    run_stream(1'b1, 1'b0, 1'b1);

    // Row 0 of this tile was written in the done cycle above.
    for (int r = 1; r < D; r++) write_row(r, DW'($urandom));
    run_stream(1'b0, 1'b0, 1'b0);

    // Random tiles with random disturbance.
    for (int n = 0; n < 4; n++) begin
      load_tile(1'b0);
      repeat ($urandom_range(0, 3)) cyc();
      run_stream(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_skew_feeder.md
PE_SKEW_FEEDER -- requirements
Module: pe_skew_feeder

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; matches the PE operand width.
REQ-002 Parameter: LANES, 4, number of PE array edge lanes fed.
REQ-003 Parameter: DEPTH, 4, number of row vectors per tile.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_valid  input  1  row-vector write request.
REQ-007 wr_ready  output  1  feeder can accept a row this cycle.
REQ-008 wr_data  input  LANES*WIDTH  row vector; lane 0 in bits [WIDTH-1:0].
REQ-009 start  input  1  request to stream the loaded tile.
REQ-010 busy  output  1  high while streaming.
REQ-011 pe_enable  output  1  enable driven to the PE array; high only on valid operand cycles.
REQ-012 a_out  output  LANES*WIDTH  skewed operands to the PE array edge; lane 0 in LSBs.
REQ-013 done  output  1  one-cycle pulse after the last streamed step.

Function
REQ-014 States SHALL be EMPTY, LOADING, FULL and STREAM; reset enters EMPTY.
REQ-015 A write SHALL complete when wr_valid and wr_ready are both high at a rising edge; row index = current row count.
REQ-016 wr_ready SHALL be high in EMPTY and LOADING, and low in FULL and STREAM.
REQ-017 The first write SHALL move EMPTY->LOADING; the write that makes the count equal DEPTH SHALL move the block to FULL.
REQ-018 start SHALL be honoured only in FULL; in EMPTY, LOADING or STREAM it SHALL be ignored with no side effect.
REQ-019 On the edge where start is sampled in FULL, the block SHALL enter STREAM, set step t=0, and register step-0 outputs.
REQ-020 Stream length SHALL be DEPTH+LANES-1 steps (7 by default); step t is visible on outputs during the t-th cycle after the start edge.
REQ-021 During step t, lane i SHALL output row[t-i] lane i when 0 <= t-i < DEPTH, and 0 otherwise.
REQ-022 pe_enable and busy SHALL be high for exactly DEPTH+LANES-1 consecutive cycles.
REQ-023 In the cycle after the last step: done=1, pe_enable=0, busy=0, a_out=0, state EMPTY, row count 0, wr_ready=1.
REQ-024 A write presented in the done cycle SHALL be accepted as row 0 of the next tile.
REQ-025 Outside STREAM, a_out SHALL be 0 and pe_enable SHALL be 0.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to a_out, pe_enable or done.
REQ-027 Tile buffer contents SHALL NOT be cleared on tile completion; rows are overwritten by subsequent writes.

Reset
REQ-028 Asserting reset SHALL immediately force state EMPTY, row count 0, step 0, wr_ready=1, busy=0, pe_enable=0, done=0 and a_out=0, including mid-load and mid-stream.
REQ-029 The tile buffer need not be reset; its contents SHALL be unobservable until rows are rewritten.
REQ-030 After reset deasserts, the first write SHALL be accepted on the first rising edge.

Structure
REQ-031 WIDTH, LANES, DEPTH and the state encoding SHALL live in the shared sa_pkg package used by the datapath.
REQ-032 The DEPTH x LANES x WIDTH storage SHALL be a sub-module tile_buf with one write port and LANES independent per-lane read ports.
REQ-033 The FSM, row counter, step counter and per-lane skew index logic SHALL reside in pe_skew_feeder.

Verification
REQ-034 Load rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, then pulse start -> a_out = 0x00000001, 0x00000205, 0x00030609, 0x04070A0D, 0x080B0E00, 0x0C0F0000, 0x10000000 on 7 consecutive pe_enable cycles, then done=1 for one cycle.
REQ-035 Load 2 rows, then pulse start -> no pe_enable; state stays LOADING; wr_ready=1.
REQ-036 Hold wr_valid=1 continuously -> exactly 4 writes accepted; wr_ready=0 after the 4th; start is then accepted.
REQ-037 Assert reset at stream step 3 -> a_out=0 and pe_enable=0 immediately; wr_ready=1; a fresh 4-row load and start reproduce the REQ-034 sequence.
REQ-038 Pulse start during STREAM and write during STREAM -> no restart, no write accepted, sequence unchanged.
REQ-039 Write row 0 in the done cycle -> accepted; state becomes LOADING with count 1.
